// File: rtl/counter_event_monitor_if.sv
`default_nettype none
// =============================================================================
//  Module   : counter_event_monitor_if
//  Brief    : Observation bus between an up/down counter and its event monitor.
//  Revision : 1.0 - initial release
// =============================================================================
interface counter_event_monitor_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       s_in;
    logic [WIDTH-1:0] load_data_in;
    logic [WIDTH-1:0] count_in;
    logic [WIDTH-1:0] match_value_in;
    logic             clear_in;

    logic             wrap_up_o;
    logic             wrap_down_o;
    logic             match_o;
    logic             stall_o;
    logic [7:0]       wrap_count_o;
    logic [2:0]       state_o;
    logic             step_err_o;

    modport master (
        output s_in, load_data_in, count_in, match_value_in, clear_in,
        input  wrap_up_o, wrap_down_o, match_o, stall_o, wrap_count_o,
               state_o, step_err_o
    );

    modport slave (
        input  s_in, load_data_in, count_in, match_value_in, clear_in,
        output wrap_up_o, wrap_down_o, match_o, stall_o, wrap_count_o,
               state_o, step_err_o
    );
endinterface
`default_nettype wire

// File: rtl/counter_event_monitor.sv
`default_nettype none
// =============================================================================
//  Module   : counter_event_monitor
//  Brief    : Passive observer of an up/down counter: wrap, match and stall
//             detection plus a saturating wrap tally. Optional STEP_CHECK_EN
//             macro adds a next-count consistency check (step_err_o).
//  Revision : 1.0 - initial release
// =============================================================================
module counter_event_monitor #(
    parameter int WIDTH      = 8,
    parameter int HOLD_LIMIT = 16
) (
    input  logic                      clk_in,
    input  logic                      reset_in,
    counter_event_monitor_if.slave    bus
);

    localparam logic [1:0]       c_mode_hold = 2'b00;
    localparam logic [1:0]       c_mode_inc  = 2'b01;
    localparam logic [1:0]       c_mode_dec  = 2'b10;
    localparam logic [WIDTH-1:0] c_cnt_max   = '1;
    localparam logic [WIDTH-1:0] c_cnt_zero  = '0;
    localparam logic [7:0]       c_sat       = 8'hFF;
    localparam logic [7:0]       c_hold_limit = 8'(HOLD_LIMIT);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UP   = 3'd1,
        ST_DOWN = 3'd2,
        ST_HOLD = 3'd3,
        ST_LOAD = 3'd4
    } state_t;

    state_t           r_state;
    logic             r_valid;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap_up;
    logic             r_wrap_down;
    logic             r_match;
    logic             r_stall;
    logic [7:0]       r_wrap_count;
    logic [7:0]       r_hold_cnt;

    logic             w_wrap_up;
    logic             w_wrap_down;
    logic             w_match;
    logic [7:0]       w_hold_next;
    state_t           w_next_state;

    // Events judge last cycle's request (r_mode/r_cnt) against this cycle's count.
    assign w_wrap_up   = r_valid && (r_mode == c_mode_inc) && (r_cnt == c_cnt_max)
                         && (bus.count_in == c_cnt_zero);
    assign w_wrap_down = r_valid && (r_mode == c_mode_dec) && (r_cnt == c_cnt_zero)
                         && (bus.count_in == c_cnt_max);
    assign w_match     = r_valid && (bus.count_in == bus.match_value_in)
                         && (bus.count_in != r_cnt);
    assign w_hold_next = (r_hold_cnt == c_sat) ? c_sat : r_hold_cnt + 8'd1;

    always_comb begin
        w_next_state = ST_IDLE;
        case (bus.s_in)
            2'b00:   w_next_state = ST_HOLD;
            2'b01:   w_next_state = ST_UP;
            2'b10:   w_next_state = ST_DOWN;
            default: w_next_state = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state      <= ST_IDLE;
            r_valid      <= 1'b0;
            r_mode       <= c_mode_hold;
            r_cnt        <= c_cnt_zero;
            r_wrap_up    <= 1'b0;
            r_wrap_down  <= 1'b0;
            r_match      <= 1'b0;
            r_stall      <= 1'b0;
            r_wrap_count <= 8'd0;
            r_hold_cnt   <= 8'd0;
        end else begin
            r_state     <= w_next_state;
            r_valid     <= 1'b1;
            r_mode      <= bus.s_in;
            r_cnt       <= bus.count_in;
            r_wrap_up   <= w_wrap_up;
            r_wrap_down <= w_wrap_down;
            r_match     <= w_match;

            if (bus.clear_in) begin
                r_wrap_count <= 8'd0;
            end else if ((w_wrap_up || w_wrap_down) && (r_wrap_count != c_sat)) begin
                r_wrap_count <= r_wrap_count + 8'd1;
            end

            // Saturating run length means HOLD_LIMIT is crossed once per run,
            // so a clear keeps stall low for the rest of that run.
            if (bus.s_in == c_mode_hold) begin
                r_hold_cnt <= w_hold_next;
                if (bus.clear_in) begin
                    r_stall <= 1'b0;
                end else if (w_hold_next == c_hold_limit) begin
                    r_stall <= 1'b1;
                end
            end else begin
                r_hold_cnt <= 8'd0;
                r_stall    <= 1'b0;
            end
        end
    end

`ifdef STEP_CHECK_EN
    logic [WIDTH-1:0] r_ld;
    logic             r_step_err;
    logic [WIDTH-1:0] w_expected;

    always_comb begin
        w_expected = r_ld;
        case (r_mode)
            2'b00:   w_expected = r_cnt;
            2'b01:   w_expected = r_cnt + 1'b1;
            2'b10:   w_expected = r_cnt - 1'b1;
            default: w_expected = r_ld;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_ld       <= c_cnt_zero;
            r_step_err <= 1'b0;
        end else begin
            r_ld       <= bus.load_data_in;
            r_step_err <= r_valid && (bus.count_in != w_expected);
        end
    end

    assign bus.step_err_o = r_step_err;
`else
    assign bus.step_err_o = 1'b0;
`endif

    assign bus.wrap_up_o    = r_wrap_up;
    assign bus.wrap_down_o  = r_wrap_down;
    assign bus.match_o      = r_match;
    assign bus.stall_o      = r_stall;
    assign bus.wrap_count_o = r_wrap_count;
    assign bus.state_o      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_counter_event_monitor.sv
`default_nettype none
// =============================================================================
//  Module   : tb_counter_event_monitor
//  Brief    : Directed plus randomized bench for counter_event_monitor against
//             a behavioural reference model.
//  Revision : 1.0 - initial release
// =============================================================================
module tb_counter_event_monitor;

    localparam int WIDTH      = 8;
    localparam int HOLD_LIMIT = 16;

    logic clk_in   = 1'b0;
    logic reset_in = 1'b1;

    counter_event_monitor_if #(.WIDTH(WIDTH)) bus ();

    counter_event_monitor #(
        .WIDTH      (WIDTH),
        .HOLD_LIMIT (HOLD_LIMIT)
    ) dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    int nvec = 0;
    int nerr = 0;

    // Reference model: previous sample plus expected outputs
    int m_valid, m_mode, m_cnt, m_ld, m_hold_run;
    int e_wu, e_wd, e_m, e_stall, e_tally, e_state, e_se;
    int state_of_mode [4] = '{3, 1, 2, 4};
    int ctr  = 0;
    int mv_g = 0;

    function automatic int next_count(input int c, input int s, input int ld);
        case (s)
            0:       return c;
            1:       return (c + 1) % 256;
            2:       return (c + 255) % 256;
            default: return ld;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_mode = 0; m_cnt = 0; m_ld = 0; m_hold_run = 0;
        e_wu = 0; e_wd = 0; e_m = 0; e_stall = 0; e_tally = 0; e_state = 0; e_se = 0;
    endtask

    task automatic model_edge(input int s, input int ld, input int cnt, input int mv, input int clr);
        e_wu = (m_valid == 1 && m_mode == 1 && m_cnt == 255 && cnt == 0) ? 1 : 0;
        e_wd = (m_valid == 1 && m_mode == 2 && m_cnt == 0 && cnt == 255) ? 1 : 0;
        e_m  = (m_valid == 1 && cnt == mv && cnt != m_cnt) ? 1 : 0;
        if (clr != 0)              e_tally = 0;
        else if (e_wu + e_wd > 0)  e_tally = (e_tally < 255) ? e_tally + 1 : 255;
        e_state = state_of_mode[s];
        m_hold_run = (s == 0) ? ((m_hold_run < 255) ? m_hold_run + 1 : 255) : 0;
        if (clr != 0 || s != 0)            e_stall = 0;
        else if (m_hold_run == HOLD_LIMIT) e_stall = 1;
`ifdef STEP_CHECK_EN
        e_se = (m_valid == 1 && cnt != next_count(m_cnt, m_mode, m_ld)) ? 1 : 0;
`else
        e_se = 0;
`endif
        m_valid = 1; m_mode = s; m_cnt = cnt; m_ld = ld;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        nvec++;
        assert (obs === 32'(exp)) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ":wrap_up"},    32'(bus.wrap_up_o),    e_wu);
        chk({where, ":wrap_down"},  32'(bus.wrap_down_o),  e_wd);
        chk({where, ":match"},      32'(bus.match_o),      e_m);
        chk({where, ":stall"},      32'(bus.stall_o),      e_stall);
        chk({where, ":wrap_count"}, 32'(bus.wrap_count_o), e_tally);
        chk({where, ":state"},      32'(bus.state_o),      e_state);
        chk({where, ":step_err"},   32'(bus.step_err_o),   e_se);
    endtask

    task automatic cycle_raw(input string where, input int s, input int ld,
                             input int cnt, input int clr);
        bus.s_in           = 2'(s);
        bus.load_data_in   = 8'(ld);
        bus.count_in       = 8'(cnt);
        bus.match_value_in = 8'(mv_g);
        bus.clear_in       = (clr != 0);
        @(posedge clk_in);
        model_edge(s, ld, cnt, mv_g, clr);
        #1;
        check_all(where);
    endtask

    // Present a well-behaved counter: count_in follows the requested mode
    task automatic step(input string where, input int s, input int ld, input int clr);
        cycle_raw(where, s, ld, ctr, clr);
        ctr = next_count(ctr, s, ld);
    endtask

    task automatic do_reset(input string where);
        #2;
        reset_in = 1'b1;
        #1;
        model_reset();
        check_all(where);
        #2;
        reset_in = 1'b0;
    endtask

    initial begin
        bus.s_in = 2'b00; bus.load_data_in = '0; bus.count_in = '0;
        bus.match_value_in = '0; bus.clear_in = 1'b0;
        model_reset();
        #3;
        check_all("por");
        @(posedge clk_in); #1;
        check_all("por_hold");
        #4;
        reset_in = 1'b0;

        // Async reset in the middle of counting at 37
        step("pre", 3, 34, 0);
        for (int i = 0; i < 3; i++) step("inc37", 1, 0, 0);
        do_reset("mid_reset");
        for (int i = 0; i < 3; i++) step("post_reset", 1, 0, 0);

        // LOAD 255 then INC -> roll-over
        step("ld255", 3, 255, 0);
        step("inc_wrap", 1, 0, 0);
        step("wrap_up", 1, 0, 0);
        step("wrap_up_after", 1, 0, 0);

        // LOAD 0 then DEC -> roll-under
        step("ld0", 3, 0, 0);
        step("dec_wrap", 2, 0, 0);
        step("wrap_down", 2, 0, 0);
        step("wrap_down_after", 2, 0, 0);

        // Match entry then long HOLD for stall, cleared mid-run, then INC
        mv_g = 45;
        step("ld40", 3, 40, 0);
        for (int i = 0; i < 5; i++)  step("inc_to_45", 1, 0, 0);
        for (int i = 0; i < 20; i++) step("hold45", 0, 0, 0);
        step("inc_exit", 1, 0, 0);
        for (int i = 0; i < 18; i++) step("hold_b", 0, 0, 0);
        step("hold_clear", 0, 0, 1);
        for (int i = 0; i < 3; i++)  step("hold_after_clr", 0, 0, 0);
        step("inc_exit2", 1, 0, 0);
        mv_g = 0;

        // 260 wraps -> saturation at 255
        for (int i = 0; i < 260; i++) begin
            step("sat_ld", 3, 255, 0);
            step("sat_inc", 1, 0, 0);
        end
        step("sat_last", 3, 255, 0);
        step("sat_inc2", 1, 0, 0);
        step("clr_with_wrap", 3, 255, 1);
        step("after_clr", 1, 0, 0);

        // Count jumps 200 -> 202 under INC
        step("ld200", 3, 200, 0);
        step("inc200", 1, 0, 0);
        cycle_raw("skip202", 1, 0, 202, 0);
        ctr = 203;
        step("after_skip", 1, 0, 0);

        // Randomized traffic with occasional glitches, clears and resets
        for (int n = 0; n < 400; n++) begin
            int s, ld, clr;
            s   = int'($urandom_range(0, 3));
            ld  = int'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) ld = ($urandom_range(0, 1) == 0) ? 0 : 255;
            clr = ($urandom_range(0, 19) == 0) ? 1 : 0;
            if ($urandom_range(0, 7) == 0) mv_g = (ctr + 1) % 256;
            if ($urandom_range(0, 24) == 0) begin
                int len;
                len = int'($urandom_range(10, 25));
                for (int k = 0; k < len; k++) step("rnd_hold", 0, 0, 0);
            end else if ($urandom_range(0, 15) == 0) begin
                int g;
                g = int'($urandom_range(0, 255));
                cycle_raw("rnd_glitch", s, ld, g, clr);
                ctr = next_count(g, s, ld);
            end else if ($urandom_range(0, 99) == 0) begin
                do_reset("rnd_reset");
            end else begin
                step("rnd", s, ld, clr);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
